// File: rtl/vga_glyph_renderer.sv
// Glyph-string renderer feeding the vga_adapter pixel port: power-on clear, erase of the previous footprint, then draw.
// Optional macro VGA_GLYPH_SCALE2_EN draws every bitmap bit as a 2x2 pixel block.
module vga_glyph_renderer #(
  parameter int GLYPH_W    = 12,
  parameter int GLYPH_H    = 12,
  parameter int NUM_GLYPHS = 3,
  parameter int GAP        = 0,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COL_W      = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyphs,
  input  logic [X_W-1:0]                        x,
  input  logic [Y_W-1:0]                        y,
  input  logic [COL_W-1:0]                      colour_in,
  input  logic [COL_W-1:0]                      bg_colour,
  output logic [X_W-1:0]                        x_out,
  output logic [Y_W-1:0]                        y_out,
  output logic [COL_W-1:0]                      colour,
  output logic                                  writeEn,
  output logic                                  busy,
  output logic                                  done
);

`ifdef VGA_GLYPH_SCALE2_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  localparam int N_BITS = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int PITCH  = SCALE * (GLYPH_W + GAP);
  localparam int G_W    = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int R_W    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int C_W    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int I_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    S_SCREEN_CLR,
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   glyphs_q, glyphs_d;
  logic [X_W-1:0]      cur_x_q, cur_x_d, prev_x_q, prev_x_d;
  logic [Y_W-1:0]      cur_y_q, cur_y_d, prev_y_q, prev_y_d;
  logic [X_W-1:0]      clr_x_q, clr_x_d, x_out_q, x_out_d;
  logic [Y_W-1:0]      clr_y_q, clr_y_d, y_out_q, y_out_d;
  logic [COL_W-1:0]    fg_q, fg_d, colour_q, colour_d;
  logic                drawn_valid_q, drawn_valid_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic [G_W-1:0]      g_q, g_d;
  logic [R_W-1:0]      r_q, r_d;
  logic [C_W-1:0]      c_q, c_d;
  logic                sx_q, sx_d, sy_q, sy_d;

  logic                sweep_step;
  logic                sweep_last;
  logic [X_W-1:0]      org_x, px;
  logic [Y_W-1:0]      org_y, py;
  logic [I_W-1:0]      bit_idx;

  // Pixel coordinate and bitmap bit for the current sweep position; sums wrap at the port widths.
  always_comb begin
    org_x   = (state_q == S_ERASE) ? prev_x_q : cur_x_q;
    org_y   = (state_q == S_ERASE) ? prev_y_q : cur_y_q;
    px      = org_x + X_W'(32'(g_q) * 32'(PITCH)) + X_W'(32'(c_q) * 32'(SCALE)) + X_W'(sx_q);
    py      = org_y + Y_W'(32'(r_q) * 32'(SCALE)) + Y_W'(sy_q);
    bit_idx = I_W'(32'(N_BITS - 1)
                   - (32'(g_q) * 32'(GLYPH_W * GLYPH_H) + 32'(r_q) * 32'(GLYPH_W) + 32'(c_q)));
    sweep_last = ((SCALE == 1) || (sx_q && sy_q))
                 && (c_q == C_W'(GLYPH_W - 1))
                 && (r_q == R_W'(GLYPH_H - 1))
                 && (g_q == G_W'(NUM_GLYPHS - 1));
  end

  always_comb begin
    state_d       = state_q;
    glyphs_d      = glyphs_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    prev_x_d      = prev_x_q;
    prev_y_d      = prev_y_q;
    clr_x_d       = clr_x_q;
    clr_y_d       = clr_y_q;
    x_out_d       = x_out_q;
    y_out_d       = y_out_q;
    fg_d          = fg_q;
    colour_d      = colour_q;
    drawn_valid_d = drawn_valid_q;
    wr_en_d       = 1'b0;
    done_d        = 1'b0;
    g_d           = g_q;
    r_d           = r_q;
    c_d           = c_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    sweep_step    = 1'b0;

    case (state_q)
      S_SCREEN_CLR: begin
        wr_en_d  = 1'b1;
        colour_d = bg_colour;
        x_out_d  = clr_x_q;
        y_out_d  = clr_y_q;
        if (clr_x_q == X_W'(SCREEN_W - 1)) begin
          clr_x_d = '0;
          if (clr_y_q == Y_W'(SCREEN_H - 1)) begin
            clr_y_d = '0;
            state_d = S_IDLE;
          end else begin
            clr_y_d = clr_y_q + Y_W'(1);
          end
        end else begin
          clr_x_d = clr_x_q + X_W'(1);
        end
      end
      S_IDLE: begin
        if (start) begin
          glyphs_d = glyphs;
          cur_x_d  = x;
          cur_y_d  = y;
          fg_d     = colour_in;
          g_d      = '0;
          r_d      = '0;
          c_d      = '0;
          sx_d     = 1'b0;
          sy_d     = 1'b0;
          state_d  = drawn_valid_q ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE: begin
        sweep_step = 1'b1;
        wr_en_d    = 1'b1;
        colour_d   = bg_colour;
        x_out_d    = px;
        y_out_d    = py;
        if (sweep_last) state_d = S_DRAW;
      end
      S_DRAW: begin
        sweep_step = 1'b1;
        wr_en_d    = glyphs_q[bit_idx];
        colour_d   = fg_q;
        x_out_d    = px;
        y_out_d    = py;
        if (sweep_last) state_d = S_DONE;
      end
      S_DONE: begin
        done_d        = 1'b1;
        prev_x_d      = cur_x_q;
        prev_y_d      = cur_y_q;
        drawn_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Sub-pixel x, sub-pixel y, column, row, glyph; every counter wraps to zero on the last pixel.
    if (sweep_step) begin
      if ((SCALE == 2) && !sx_q) begin
        sx_d = 1'b1;
      end else begin
        sx_d = 1'b0;
        if ((SCALE == 2) && !sy_q) begin
          sy_d = 1'b1;
        end else begin
          sy_d = 1'b0;
          if (c_q == C_W'(GLYPH_W - 1)) begin
            c_d = '0;
            if (r_q == R_W'(GLYPH_H - 1)) begin
              r_d = '0;
              if (g_q == G_W'(NUM_GLYPHS - 1)) g_d = '0;
              else g_d = g_q + G_W'(1);
            end else begin
              r_d = r_q + R_W'(1);
            end
          end else begin
            c_d = c_q + C_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_SCREEN_CLR;
      glyphs_q      <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      prev_x_q      <= '0;
      prev_y_q      <= '0;
      clr_x_q       <= '0;
      clr_y_q       <= '0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      fg_q          <= '0;
      colour_q      <= '0;
      drawn_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
      g_q           <= '0;
      r_q           <= '0;
      c_q           <= '0;
      sx_q          <= 1'b0;
      sy_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      glyphs_q      <= glyphs_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      prev_x_q      <= prev_x_d;
      prev_y_q      <= prev_y_d;
      clr_x_q       <= clr_x_d;
      clr_y_q       <= clr_y_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      fg_q          <= fg_d;
      colour_q      <= colour_d;
      drawn_valid_q <= drawn_valid_d;
      wr_en_q       <= wr_en_d;
      done_q        <= done_d;
      g_q           <= g_d;
      r_q           <= r_d;
      c_q           <= c_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
    end
  end

  assign x_out   = x_out_q;
  assign y_out   = y_out_q;
  assign colour  = colour_q;
  assign writeEn = wr_en_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_glyph_renderer.sv
// Bench for vga_glyph_renderer: expected pixel writes come from a footprint model over the bitmap rules.
module tb_vga_glyph_renderer;

`ifdef VGA_GLYPH_SCALE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int GW  = 12;
  localparam int GH  = 12;
  localparam int NG  = 3;
  localparam int GAP = 0;
  localparam int GB  = NG * GW * GH;
  localparam int W   = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [GB-1:0] glyphs = '0;
  logic [7:0]    x = '0;
  logic [6:0]    y = '0;
  logic [2:0]    colour_in = '0;
  logic [2:0]    bg_col = '0;
  logic [7:0]    x_out;
  logic [6:0]    y_out;
  logic [2:0]    colour;
  logic          wr_en;
  logic          busy;
  logic          done;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_obs;
  logic [W-1:0]  mon_exp;
  int            n_cmp = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  bit            m_valid = 1'b0;
  int            m_x = 0;
  int            m_y = 0;

  vga_glyph_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .glyphs    (glyphs),
    .x         (x),
    .y         (y),
    .colour_in (colour_in),
    .bg_colour (bg_col),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .writeEn   (wr_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input int px, input int py, input logic [2:0] c);
    logic [7:0] xm;
    logic [6:0] ym;
    xm = 8'(px % 256);
    ym = 7'(py % 128);
    return {xm, ym, c};
  endfunction

  // Scoreboard: every write seen on the pixel port must be the next expected one.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      mon_obs = {x_out, y_out, colour};
      check("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("pixel", mon_obs, mon_exp);
      end
    end
  end

  task automatic push_clear();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        exp_q.push_back(pix(xx, yy, bg_col));
  endtask

  task automatic model_push(input logic [GB-1:0] gl, input int ox, input int oy,
                            input logic [2:0] fg, output int lat);
    int pitch;
    pitch = S * (GW + GAP);
    lat = 2 + S * S * GB;
    if (m_valid) begin
      lat += S * S * GB;
      for (int g = 0; g < NG; g++)
        for (int r = 0; r < GH; r++)
          for (int c = 0; c < GW; c++)
            for (int sy = 0; sy < S; sy++)
              for (int sx = 0; sx < S; sx++)
                exp_q.push_back(pix(m_x + g * pitch + c * S + sx, m_y + r * S + sy, bg_col));
    end
    for (int g = 0; g < NG; g++)
      for (int r = 0; r < GH; r++)
        for (int c = 0; c < GW; c++)
          if (gl[GB - 1 - (g * GW * GH + r * GW + c)])
            for (int sy = 0; sy < S; sy++)
              for (int sx = 0; sx < S; sx++)
                exp_q.push_back(pix(ox + g * pitch + c * S + sx, oy + r * S + sy, fg));
    m_valid = 1'b1;
    m_x = ox;
    m_y = oy;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (cyc < 25000 && !(busy == 1'b0 && wr_en == 1'b0)) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_timeout", cyc < 25000, 1);
  endtask

  task automatic do_request(input string tag, input logic [GB-1:0] gl, input logic [7:0] ox,
                            input logic [6:0] oy, input logic [2:0] fg, input bit poke);
    int exp_lat;
    int cyc;
    int d0;
    model_push(gl, int'(ox), int'(oy), fg, exp_lat);
    d0 = done_cnt;
    @(negedge clk);
    glyphs = gl;
    x = ox;
    y = oy;
    colour_in = fg;
    start = 1'b1;
    cyc = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == exp_lat - 100) begin
        start = 1'b1;
        x = ~x;
        glyphs = ~glyphs;
        colour_in = ~colour_in;
      end
      if (poke && cyc == exp_lat - 99) start = 1'b0;
      if (done) break;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    repeat (3) @(negedge clk);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    logic [GB-1:0] gl;
    int lat;

    bg_col = 3'($urandom_range(1, 7));
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_colour", colour, 0);
    check("rst_write", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 1);
    repeat (2) @(negedge clk);
    push_clear();
    reset = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("clr_queue_empty", exp_q.size(), 0);
    check("clr_busy_low", busy, 0);

    gl = '0;
    gl[GB-1 -: GW*GH] = '1;
    do_request("first", gl, 8'd10, 7'd20, 3'($urandom_range(1, 7)), 1'b0);
    do_request("redraw", gl, 8'd50, 7'd20, 3'($urandom_range(1, 7)), 1'b0);

    for (int i = 0; i < GB; i++) gl[i] = 1'($urandom_range(0, 1));
    do_request("busy_start", gl, 8'($urandom), 7'($urandom), 3'($urandom_range(1, 7)), 1'b1);

    gl = '0;
    gl[GB-1] = 1'b1;
    gl[GB-1-(GW*GH)-(GW*GH-1)] = 1'b1;
    do_request("wrap", gl, 8'd250, 7'd125, 3'($urandom_range(1, 7)), 1'b0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < GB; i++) gl[i] = 1'($urandom_range(0, 1));
      do_request("random", gl, 8'($urandom), 7'($urandom), 3'($urandom_range(0, 7)), 1'b0);
    end

    for (int i = 0; i < GB; i++) gl[i] = 1'($urandom_range(0, 1));
    model_push(gl, 30, 40, 3'd5, lat);
    @(negedge clk);
    glyphs = gl;
    x = 8'd30;
    y = 7'd40;
    colour_in = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_erase_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_write", wr_en, 0);
    check("midrst_x_out", x_out, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 1);
    exp_q.delete();
    m_valid = 1'b0;
    push_clear();
    @(negedge clk);
    reset = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("clr2_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < GB; i++) gl[i] = 1'($urandom_range(0, 1));
    do_request("after_reset", gl, 8'($urandom), 7'($urandom), 3'($urandom_range(1, 7)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
